// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter and frame sequencer for a shared UART transmit shift register.
// Define UART_TX_ARB_FIXED_PRI_EN for fixed priority (lowest asserted index wins).
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no owner; arbitrate among req, latch winner's byte
// S_LOAD  | one-cycle parallel-load strobe, counters cleared
// S_WAIT  | bit-period timer running (CLKS_PER_BIT-1 cycles)
// S_SHIFT | one-cycle shift strobe, advance bit counter
// S_DONE  | one-cycle done pulse to the owner, release grant
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 434,
  parameter int FRAME_BITS   = 10
) (
  input  logic                 CLOCK_50,
  input  logic                 Reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] data_in,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic [7:0]           tx_data,
  output logic                 load,
  output logic                 enable,
  output logic                 busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int PER_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAIT  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q;
  logic [7:0]         tx_data_q;
  logic [PER_W-1:0]   per_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand_idx;
  int                 cand;

`ifndef UART_TX_ARB_FIXED_PRI_EN
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner_q;
`endif

  // Scan from the pointer upward so the last owner has lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef UART_TX_ARB_FIXED_PRI_EN
      cand = i;
`else
      cand = (int'(rr_ptr) + i) % NUM_REQ;
`endif
      cand_idx = IDX_W'(cand);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    enable  = 1'b0;
    done    = '0;
    busy    = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (win_found) state_d = S_LOAD;
      end
      S_LOAD: begin
        load    = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (per_cnt == PER_W'(CLKS_PER_BIT - 2)) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        enable  = 1'b1;
        state_d = (bit_cnt == BIT_W'(FRAME_BITS - 1)) ? S_DONE : S_WAIT;
      end
      S_DONE: begin
        done    = grant_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      grant_q   <= '0;
      tx_data_q <= '0;
      per_cnt   <= '0;
      bit_cnt   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            grant_q   <= NUM_REQ'(1) << win_idx;
            tx_data_q <= data_in[{win_idx, 3'b000} +: 8];
          end
        end
        S_LOAD: begin
          per_cnt <= '0;
          bit_cnt <= '0;
        end
        S_WAIT: begin
          per_cnt <= per_cnt + PER_W'(1);
        end
        S_SHIFT: begin
          per_cnt <= '0;
          bit_cnt <= bit_cnt + BIT_W'(1);
        end
        S_DONE: begin
          grant_q <= '0;
        end
        default: begin
          grant_q <= '0;
        end
      endcase
    end
  end

`ifndef UART_TX_ARB_FIXED_PRI_EN
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      rr_ptr  <= '0;
      owner_q <= '0;
    end else begin
      if (state_q == S_IDLE && win_found) owner_q <= win_idx;
      if (state_q == S_DONE)
        rr_ptr <= (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
    end
  end
`endif

  assign grant   = grant_q;
  assign tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: table of whole-frame vectors plus a
// hand-written asynchronous mid-frame reset sequence.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int CLKS_PER_BIT = 4;
  localparam int FRAME_BITS   = 10;

  logic        CLOCK_50;
  logic        Reset;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [7:0]  tx_data;
  logic        load;
  logic        enable;
  logic        busy;

  int n_checks;
  int n_errors;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .FRAME_BITS(FRAME_BITS)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .Reset(Reset),
    .req(req),
    .data_in(data_in),
    .grant(grant),
    .done(done),
    .tx_data(tx_data),
    .load(load),
    .enable(enable),
    .busy(busy)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // act: 0 none, 1 overwrite byte 1 with 0xFF, 2 drop req[2]; applied once en_cnt == act_en
  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  next_req;
    logic [3:0]  exp_grant;
    logic [7:0]  exp_tx;
    int          act;
    int          act_en;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_load(input string name, output int k, output bit ok);
    k  = 0;
    ok = 1'b0;
    while (k < 30 && !ok) begin
      @(negedge CLOCK_50);
      k++;
      if (load) ok = 1'b1;
    end
    if (!ok) check({name, "_load_timeout"}, 0, 1);
  endtask

  task automatic do_frame(input vec_t v, input string name);
    int k, cyc, since, en_cnt, done_at, spacing_err, stab_err, extra_load;
    bit ok, got_done, acted;
    wait_load(name, k, ok);
    if (!ok) return;
    if (v.exp_lat != 0) check({name, "_latency"}, k, v.exp_lat);
    check({name, "_grant"}, grant, v.exp_grant);
    check({name, "_tx_data"}, tx_data, v.exp_tx);
    check({name, "_busy_at_load"}, busy, 1);
    cyc = 0; since = 0; en_cnt = 0; done_at = 0;
    spacing_err = 0; stab_err = 0; extra_load = 0;
    got_done = 1'b0; acted = 1'b0;
    while (!got_done && cyc < 100) begin
      if (v.act != 0 && !acted && en_cnt == v.act_en) begin
        if (v.act == 1) data_in[15:8] = 8'hFF;
        else            req[2] = 1'b0;
        acted = 1'b1;
      end
      @(negedge CLOCK_50);
      cyc++;
      since++;
      if (enable) begin
        en_cnt++;
        if (since != CLKS_PER_BIT) spacing_err++;
        since = 0;
      end
      if (load) extra_load++;
      if (tx_data !== v.exp_tx || grant !== v.exp_grant || busy !== 1'b1) stab_err++;
      if ((int'(load) + int'(enable) + int'(|done)) > 1) stab_err++;
      if (|done) begin
        got_done = 1'b1;
        done_at  = cyc;
        check({name, "_done_vector"}, done, v.exp_grant);
        req = v.next_req;
      end
    end
    check({name, "_done_seen"}, got_done, 1);
    check({name, "_enable_count"}, en_cnt, FRAME_BITS);
    check({name, "_enable_spacing_errs"}, spacing_err, 0);
    check({name, "_extra_loads"}, extra_load, 0);
    check({name, "_stability_errs"}, stab_err, 0);
    check({name, "_done_after_load"}, done_at, FRAME_BITS * CLKS_PER_BIT + 1);
    @(negedge CLOCK_50);
    check({name, "_busy_after_done"}, busy, 0);
    check({name, "_grant_after_done"}, grant, 0);
  endtask

  initial begin
    int k, en_cnt, cyc, done_cnt;
    bit ok;
    vec_t rv;
    n_checks = 0;
    n_errors = 0;
    Reset    = 1'b1;
    req      = '0;
    data_in  = '0;

`ifdef UART_TX_ARB_FIXED_PRI_EN
    vecs[0] = '{4'hF, 32'h4433_2211, 4'hF, 4'b0001, 8'h11, 0, 0, 0};
    vecs[1] = '{4'hF, 32'h4433_2211, 4'hF, 4'b0001, 8'h11, 0, 0, 1};
    vecs[2] = '{4'hF, 32'h4433_2211, 4'h0, 4'b0001, 8'h11, 0, 0, 1};
`else
    vecs[0] = '{4'hF, 32'h4433_2211, 4'hF, 4'b0001, 8'h11, 0, 0, 0};
    vecs[1] = '{4'hF, 32'h4433_2211, 4'hF, 4'b0010, 8'h22, 0, 0, 1};
    vecs[2] = '{4'hF, 32'h4433_2211, 4'h0, 4'b0100, 8'h33, 0, 0, 1};
`endif
    vecs[3] = '{4'h1, 32'h0000_00A5, 4'h0, 4'b0001, 8'hA5, 0, 0, 1};
    vecs[4] = '{4'h2, 32'h0000_3C00, 4'h0, 4'b0010, 8'h3C, 1, 0, 1};
    vecs[5] = '{4'h4, 32'h005A_0000, 4'h0, 4'b0100, 8'h5A, 2, 3, 1};
    vecs[6] = '{4'h8, 32'hC300_0000, 4'h8, 4'b1000, 8'hC3, 0, 0, 1};
    vecs[7] = '{4'h8, 32'hC300_0000, 4'h0, 4'b1000, 8'hC3, 0, 0, 1};

    repeat (3) @(negedge CLOCK_50);
    check("reset_grant", grant, 0);
    check("reset_tx_data", tx_data, 0);
    check("reset_strobes", {load, enable, busy}, 0);
    check("reset_done", done, 0);
    Reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      req     = vecs[i].req;
      data_in = vecs[i].data;
      do_frame(vecs[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset after the 5th enable of a frame.
    req     = 4'b0100;
    data_in = 32'h0077_0000;
    wait_load("rst_frame", k, ok);
    en_cnt = 0;
    cyc    = 0;
    while (ok && en_cnt < 5 && cyc < 100) begin
      @(negedge CLOCK_50);
      cyc++;
      if (enable) en_cnt++;
    end
    check("rst_pre_enables", en_cnt, 5);
    #2 Reset = 1'b1;
    #1;
    check("rst_async_grant", grant, 0);
    check("rst_async_tx_data", tx_data, 0);
    check("rst_async_strobes", {load, enable, busy}, 0);
    check("rst_async_done", done, 0);
    req      = 4'b0010;
    data_in  = 32'h0000_9600;
    done_cnt = 0;
    repeat (3) begin
      @(negedge CLOCK_50);
      if (|done || busy) done_cnt++;
    end
    check("rst_hold_quiet", done_cnt, 0);
    Reset = 1'b0;
    rv = '{4'b0010, 32'h0000_9600, 4'h0, 4'b0010, 8'h96, 0, 0, 1};
    do_frame(rv, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit datapath between NUM_REQ requesters, using round-robin arbitration.
- The datapath is an external 10-bit shift register driven by load and enable.
- The block sequences each frame end to end:
  - grants one requester and latches its byte;
  - pulses load once;
  - pulses enable once per bit period, FRAME_BITS times;
  - signals done back to the granted requester.
- Sits between the accumulator/button logic and the transmit shift register; the bit-period timer is internal.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CLKS_PER_BIT, 434, CLOCK_50 cycles per bit period (50 MHz / 115200 baud).
- FRAME_BITS, 10, enable pulses per frame (start + 8 data + stop).

Ports:
- CLOCK_50  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester transmit request; level, held until done.
- data_in  input  8*NUM_REQ  byte for requester i is data_in[8i+7:8i].
- grant  output  NUM_REQ  one-hot, registered; identifies the current owner of the transmitter.
- done  output  NUM_REQ  one-cycle pulse to the owner when its frame ends.
- tx_data  output  8  latched byte presented to the shift register.
- load  output  1  one-cycle parallel-load strobe to the shift register.
- enable  output  1  one-cycle shift strobe, once per bit period.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, any state, including mid-frame):
  - State goes to IDLE; grant, done, tx_data, load, enable, busy all 0.
  - Round-robin pointer = 0; bit and period counters = 0.
  - Frame in progress is abandoned; no done pulse.
- States: IDLE, LOAD, WAIT, SHIFT, DONE.
- IDLE:
  - If |req: select the winner = first asserted req scanning from pointer upward, modulo NUM_REQ.
  - At that edge: set grant to one-hot(winner), tx_data <= winner's data_in slice, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD: exactly one cycle; load=1; period counter cleared; bit counter cleared; go to WAIT.
- WAIT:
  - Period counter increments each cycle.
  - When count == CLKS_PER_BIT-2, go to SHIFT.
  - Result: WAIT lasts CLKS_PER_BIT-1 cycles.
- SHIFT:
  - One cycle; enable=1; period counter cleared; bit counter increments.
  - If the bit counter was FRAME_BITS-1, go to DONE; otherwise go to WAIT.
- DONE:
  - One cycle; done[winner]=1.
  - At exit: grant cleared, pointer <= (winner+1) mod NUM_REQ; go to IDLE.
- Timing:
  - First enable is CLKS_PER_BIT cycles after the load cycle.
  - Consecutive enables are exactly CLKS_PER_BIT cycles apart.
  - Each frame has exactly FRAME_BITS enables and one load.
- Latency:
  - req sampled high in IDLE -> load high on the next cycle.
  - Last enable -> done on the next cycle.
  - done -> next frame's load at the earliest 2 cycles later (DONE, IDLE).
- Outputs load, enable, done and busy are decoded from the state; they are mutually exclusive except busy.
- Handshake:
  - tx_data is captured only at the IDLE->LOAD edge; data_in may change after grant rises.
  - req deasserted mid-frame: the frame still completes, and done still pulses.
  - req held after done: treated as a new request at the next arbitration.
- Simultaneous requests: only one grant is ever active. The just-served requester has lowest priority at the next arbitration.
- Width rules:
  - Period counter is wide enough for CLKS_PER_BIT-1.
  - Bit counter is wide enough for FRAME_BITS.
  - No wrap occurs within a frame.
- Illegal or unused state encodings recover to IDLE on the next clock.

Optional Feature:
- Macro: UART_TX_ARB_FIXED_PRI_EN.
- Defined: arbitration is fixed priority, lowest asserted index wins; the pointer is not maintained.
- Undefined: round-robin as described above.
- All timing and handshakes are identical in both builds.

Test Plan:
- Settings for all scenarios: NUM_REQ=4, CLKS_PER_BIT=4, FRAME_BITS=10.
- Single request: req=4'b0001, byte 0xA5 -> grant=0001; tx_data=0xA5; one load; 10 enables spaced 4 cycles; done[0] 41 cycles after load; busy low after DONE.
- Round-robin: req=4'b1111 held through three frames -> grants 0001, 0010, 0100 in order; each frame has exactly 10 enables. Under UART_TX_ARB_FIXED_PRI_EN: grants 0001, 0001, 0001.
- Data change after grant: data_in[15:8] changes from 0x3C to 0xFF during WAIT -> tx_data stays 0x3C for the whole frame.
- req drop: req[2] deasserted after the 3rd enable -> frame completes with 10 enables; done[2] still pulses.
- Reset mid-frame: Reset asserted after the 5th enable, asynchronously -> all outputs 0 without waiting for a clock edge; no done pulse. After release with req=0010, the next frame starts cleanly with a full 10 enables.
- Back-to-back: req[3] held high -> the load of frame 2 occurs 2 cycles after done[3] of frame 1.
